// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Boot byte stream, instruction-memory write port and status bundle
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;
    logic [15:0] words_loaded;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  busy, done, err, cpu_hold, words_loaded
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output busy, done, err, cpu_hold, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Loads a length-prefixed, XOR-checksummed byte image into IMEM
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 128
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    localparam logic [15:0] c_depth = 16'(DEPTH);

    state_t      state_q;
    logic [15:0] len_q;
    logic [7:0]  csum_q;
    logic [1:0]  byte_q;
    logic [23:0] word_q;
    logic        rx_ready_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        cpu_hold_q;
    logic        imem_we_q;
    logic [31:0] imem_addr_q;
    logic [31:0] imem_wdata_q;
    logic [15:0] words_q;

    logic        w_accept;
    logic [15:0] w_len;

    assign w_accept = bus.rx_valid & rx_ready_q;
    assign w_len    = {bus.rx_data, len_q[7:0]};

    // words_q doubles as the write index: it counts completed words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= 16'd0;
            csum_q       <= 8'd0;
            byte_q       <= 2'd0;
            word_q       <= 24'd0;
            rx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_hold_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 32'd0;
            imem_wdata_q <= 32'd0;
            words_q      <= 16'd0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        state_q    <= LEN0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        words_q    <= 16'd0;
                        csum_q     <= 8'd0;
                        byte_q     <= 2'd0;
                        cpu_hold_q <= 1'b1;
                        busy_q     <= 1'b1;
                        rx_ready_q <= 1'b1;
                    end
                end
                LEN0: begin
                    if (w_accept) begin
                        len_q[7:0] <= bus.rx_data;
                        state_q    <= LEN1;
                    end
                end
                LEN1: begin
                    if (w_accept) begin
                        len_q <= w_len;
                        if (w_len > c_depth) begin
                            state_q    <= ERR;
                            err_q      <= 1'b1;
                            busy_q     <= 1'b0;
                            rx_ready_q <= 1'b0;
                        end else if (w_len == 16'd0) begin
                            state_q <= CHK;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        csum_q <= csum_q ^ bus.rx_data;
                        byte_q <= byte_q + 2'd1;
                        case (byte_q)
                            2'd0: word_q[7:0]   <= bus.rx_data;
                            2'd1: word_q[15:8]  <= bus.rx_data;
                            2'd2: word_q[23:16] <= bus.rx_data;
                            default: begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= {14'd0, words_q, 2'b00};
                                imem_wdata_q <= {bus.rx_data, word_q};
                                words_q      <= words_q + 16'd1;
                                if (words_q + 16'd1 == len_q) begin
                                    state_q <= CHK;
                                end
                            end
                        endcase
                    end
                end
                CHK: begin
                    if (w_accept) begin
                        busy_q     <= 1'b0;
                        rx_ready_q <= 1'b0;
                        if (bus.rx_data == csum_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.imem_we      = imem_we_q;
    assign bus.imem_addr    = imem_addr_q;
    assign bus.imem_wdata   = imem_wdata_q;
    assign bus.words_loaded = words_q;
endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Self-checking bench for imem_loader with a stream-level model
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    localparam int DEPTH = 128;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        string      nm;
        int         len;
        logic [7:0] b[11];
        int         stall;
        int         start_at;
        bit         ed;
        bit         ee;
        int         ew;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if bus ();
    imem_loader #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] got_addr[$], got_data[$];
    logic [31:0] exp_addr[$], exp_data[$];
    bit m_done, m_err;
    int m_words;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            got_addr.push_back(bus.imem_addr);
            got_data.push_back(bus.imem_wdata);
        end
    end

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    // Reference: interpret the whole stream at once
    function automatic void model(bq_t s);
        int n;
        logic [7:0] cs;
        exp_addr.delete();
        exp_data.delete();
        n = int'({s[1], s[0]});
        m_words = 0;
        if (n > DEPTH) begin
            m_done = 0;
            m_err  = 1;
            return;
        end
        cs = 8'd0;
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(32'(w * 4));
            exp_data.push_back({s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
        end
        for (int i = 2; i < 2 + 4 * n; i++) cs ^= s[i];
        m_words = n;
        m_done  = (s[2+4*n] == cs);
        m_err   = !m_done;
    endfunction

    function automatic bq_t build(int n, bit bad);
        bq_t s;
        logic [7:0] cs = 8'd0;
        logic [7:0] b;
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        if (n > DEPTH) return s;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs ^= b;
            s.push_back(b);
        end
        if (bad) cs ^= 8'($urandom_range(1, 255));
        s.push_back(cs);
        return s;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (!bus.rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) chk("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    endtask

    // stall < 0 forces one idle cycle between every byte
    task automatic run_load(string nm, bq_t s, int stall, int start_at,
                            bit ed, bit ee, int ew);
        int nw;
        model(s);
        got_addr.delete();
        got_data.delete();
        pulse_start();
        for (int i = 0; i < s.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(s[i], stall < 0 ? 1 : int'($urandom_range(0, stall)));
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk({nm, "_done"}, 32'(bus.done), 32'(ed));
        chk({nm, "_err"}, 32'(bus.err), 32'(ee));
        chk({nm, "_hold"}, 32'(bus.cpu_hold), 32'(!ed));
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_rdy"}, 32'(bus.rx_ready), 32'd0);
        chk({nm, "_words"}, 32'(bus.words_loaded), 32'(ew));
        chk({nm, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        nw = got_addr.size() < exp_addr.size() ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < nw; i++) begin
            chk({nm, "_addr"}, got_addr[i], exp_addr[i]);
            chk({nm, "_data"}, got_data[i], exp_data[i]);
        end
    endtask

    vec_t tbl[6];
    bq_t  s;
    bq_t  good;

    initial begin
        tbl[0] = '{"good",   11, '{8'h02, 8'h00, 8'h20, 8'h08, 8'h43, 8'h00, 8'h22, 8'h10, 8'h85, 8'h00, 8'hDC}, 0, -1, 1'b1, 1'b0, 2};
        tbl[1] = '{"alt",    11, '{8'h02, 8'h00, 8'h20, 8'h08, 8'h43, 8'h00, 8'h22, 8'h10, 8'h85, 8'h00, 8'hDC}, -1, -1, 1'b1, 1'b0, 2};
        tbl[2] = '{"stall",  11, '{8'h02, 8'h00, 8'h20, 8'h08, 8'h43, 8'h00, 8'h22, 8'h10, 8'h85, 8'h00, 8'hDC}, 4, -1, 1'b1, 1'b0, 2};
        tbl[3] = '{"n129",    2, '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, -1, 1'b0, 1'b1, 0};
        tbl[4] = '{"n0",      3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, -1, 1'b1, 1'b0, 0};
        tbl[5] = '{"badcs",  11, '{8'h02, 8'h00, 8'h20, 8'h08, 8'h43, 8'h00, 8'h22, 8'h10, 8'h85, 8'h00, 8'hDD}, 0, -1, 1'b0, 1'b1, 2};

        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy",   32'(bus.rx_ready), 32'd0);
        chk("rst_we",    32'(bus.imem_we), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_err",   32'(bus.err), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_hold",  32'(bus.cpu_hold), 32'd1);
        chk("rst_words", 32'(bus.words_loaded), 32'd0);

        for (int k = 0; k < 6; k++) begin
            s.delete();
            for (int i = 0; i < tbl[k].len; i++) s.push_back(tbl[k].b[i]);
            run_load(tbl[k].nm, s, tbl[k].stall, tbl[k].start_at,
                     tbl[k].ed, tbl[k].ee, tbl[k].ew);
        end

        good.delete();
        for (int i = 0; i < 11; i++) good.push_back(tbl[0].b[i]);

        // start pulsed while in DATA must not restart the load
        run_load("startdata", good, 0, 6, 1'b1, 1'b0, 2);

        // mid-load reset after five data bytes, then a clean restart
        got_addr.delete();
        got_data.delete();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(good[i], 0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("midrst_nwr", 32'(got_addr.size()), 32'd1);
        chk("midrst_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy",   32'(bus.rx_ready), 32'd0);
        chk("midrst_busy",  32'(bus.busy), 32'd0);
        chk("midrst_hold",  32'(bus.cpu_hold), 32'd1);
        chk("midrst_words", 32'(bus.words_loaded), 32'd0);
        chk("midrst_we",    32'(bus.imem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_load("restart", good, 0, -1, 1'b1, 1'b0, 2);

        // largest legal image
        s = build(DEPTH, 1'b0);
        run_load("full", s, 0, -1, 1'b1, 1'b0, DEPTH);

        for (int r = 0; r < 25; r++) begin
            int kind;
            int n;
            kind = int'($urandom_range(0, 9));
            n = (kind == 0) ? int'($urandom_range(DEPTH + 1, 65535))
                            : int'($urandom_range(0, 6));
            s = build(n, $urandom_range(0, 2) == 0);
            model(s);
            run_load("rand", s, int'($urandom_range(0, 3)), -1, m_done, m_err, m_words);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
